// File: rtl/control_unit.sv
// control_unit: multi-cycle FETCH/DECODE/EXECUTE sequencer for a small
// LC-3-style datapath. It owns PC, IR and the condition codes, issues
// instruction fetches, and steers an external ALU and register file.
module control_unit (
    input  logic        clk,
    input  logic        rst,
    output logic        imem_req,
    output logic [5:0]  imem_addr,
    input  logic        imem_ready,
    input  logic [15:0] imem_data,
    output logic [1:0]  alu_op,
    output logic [1:0]  source_sel,
    output logic [5:0]  ins_immediate,
    output logic [5:0]  pc,
    input  logic [7:0]  alu_result,
    output logic [2:0]  sr1_addr,
    output logic [2:0]  sr2_addr,
    output logic [2:0]  dr_addr,
    output logic        rf_we,
    output logic [2:0]  cc,
    output logic        retire,
    output logic        halted
);

    typedef enum logic [1:0] {
        S_FETCH,
        S_DECODE,
        S_EXECUTE,
        S_HALT
    } state_t;

    localparam logic [3:0] OP_ADD  = 4'b0000;
    localparam logic [3:0] OP_AND  = 4'b0001;
    localparam logic [3:0] OP_NOT  = 4'b0010;
    localparam logic [3:0] OP_LEA  = 4'b0011;
    localparam logic [3:0] OP_BR   = 4'b0100;
    localparam logic [3:0] OP_HALT = 4'b1111;

    localparam logic [1:0] ALU_ADD = 2'b00;
    localparam logic [1:0] ALU_AND = 2'b01;
    localparam logic [1:0] ALU_NOT = 2'b10;

    localparam logic [1:0] SRC_IMM = 2'b00;
    localparam logic [1:0] SRC_PC  = 2'b01;
    localparam logic [1:0] SRC_REG = 2'b10;

    state_t      state_q, state_d;
    logic [5:0]  pc_q, pc_d;
    logic [15:0] ir_q, ir_d;
    logic [2:0]  cc_q, cc_d;
    logic        imem_req_q, imem_req_d;
    logic        rf_we_q, rf_we_d;
    logic        retire_q, retire_d;
    logic        halted_q, halted_d;

    logic [3:0]  opcode;
    logic        op_writes;
    logic        op_sets_cc;
    logic        br_taken;

    assign opcode     = ir_q[15:12];
    assign op_writes  = (opcode == OP_ADD) || (opcode == OP_AND) ||
                        (opcode == OP_NOT) || (opcode == OP_LEA);
    assign op_sets_cc = (opcode == OP_ADD) || (opcode == OP_AND) ||
                        (opcode == OP_NOT);
    assign br_taken   = (opcode == OP_BR) && ((ir_q[11:9] & cc_q) != 3'b000);

    // ALU steering decoded from the held IR; meaningful in DECODE and EXECUTE
    always_comb begin
        alu_op     = ALU_ADD;
        source_sel = SRC_IMM;
        case (opcode)
            OP_ADD: begin
                alu_op     = ALU_ADD;
                source_sel = ir_q[5] ? SRC_IMM : SRC_REG;
            end
            OP_AND: begin
                alu_op     = ALU_AND;
                source_sel = ir_q[5] ? SRC_IMM : SRC_REG;
            end
            OP_NOT: begin
                alu_op     = ALU_NOT;
                source_sel = ir_q[5] ? SRC_IMM : SRC_REG;
            end
            OP_LEA: begin
                alu_op     = ALU_ADD;
                source_sel = SRC_PC;
            end
            default: begin
                alu_op     = ALU_ADD;
                source_sel = SRC_IMM;
            end
        endcase
    end

    // Next-state, architectural state and registered-output computation.
    // Outputs are derived from the next state so they line up with the
    // state they describe once registered.
    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        ir_d    = ir_q;
        cc_d    = cc_q;
        case (state_q)
            S_FETCH: begin
                if (imem_ready) begin
                    ir_d    = imem_data;
                    pc_d    = pc_q + 6'd1;
                    state_d = S_DECODE;
                end
            end
            S_DECODE: begin
                state_d = S_EXECUTE;
            end
            S_EXECUTE: begin
                state_d = (opcode == OP_HALT) ? S_HALT : S_FETCH;
                if (op_sets_cc) begin
                    if (alu_result[7])
                        cc_d = 3'b100;
                    else if (alu_result == 8'h00)
                        cc_d = 3'b010;
                    else
                        cc_d = 3'b001;
                end
                if (br_taken)
                    pc_d = pc_q + ir_q[5:0];
            end
            S_HALT: begin
                state_d = S_HALT;
            end
            default: begin
                state_d = S_FETCH;
            end
        endcase

        imem_req_d = (state_d == S_FETCH);
        // ir_d equals ir_q on the DECODE->EXECUTE transition, so op_writes applies
        rf_we_d    = (state_d == S_EXECUTE) && op_writes;
        retire_d   = (state_d == S_EXECUTE);
        halted_d   = (state_d == S_HALT);
    end

    // Single state register; reset leaves the unit ready to fetch from 0
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= S_FETCH;
            pc_q       <= '0;
            ir_q       <= '0;
            cc_q       <= 3'b010;
            imem_req_q <= 1'b1;
            rf_we_q    <= 1'b0;
            retire_q   <= 1'b0;
            halted_q   <= 1'b0;
        end else begin
            state_q    <= state_d;
            pc_q       <= pc_d;
            ir_q       <= ir_d;
            cc_q       <= cc_d;
            imem_req_q <= imem_req_d;
            rf_we_q    <= rf_we_d;
            retire_q   <= retire_d;
            halted_q   <= halted_d;
        end
    end

    assign imem_req      = imem_req_q;
    assign imem_addr     = pc_q;
    assign pc            = pc_q;
    assign ins_immediate = ir_q[5:0];
    assign sr1_addr      = ir_q[8:6];
    assign sr2_addr      = ir_q[2:0];
    assign dr_addr       = ir_q[11:9];
    assign rf_we         = rf_we_q;
    assign cc            = cc_q;
    assign retire        = retire_q;
    assign halted        = halted_q;

endmodule

// File: tb/tb_control_unit.sv
// tb_control_unit: drives control_unit with directed and random programs.
// The bench supplies the instruction memory, an ALU and a register file,
// and predicts results from instruction semantics.
module tb_control_unit;

    logic        clk = 1'b0;
    logic        rst;
    logic        imem_req;
    logic [5:0]  imem_addr;
    logic        imem_ready;
    logic [15:0] imem_data;
    logic [1:0]  alu_op;
    logic [1:0]  source_sel;
    logic [5:0]  ins_immediate;
    logic [5:0]  pc;
    logic [7:0]  alu_result;
    logic [2:0]  sr1_addr, sr2_addr, dr_addr;
    logic        rf_we;
    logic [2:0]  cc;
    logic        retire;
    logic        halted;

    int vectors = 0;
    int miscompares = 0;

    // Reference architectural state
    logic [7:0] mregs [8];
    logic [5:0] mpc;
    logic [2:0] mcc;

    // Environment register file
    logic [7:0] regs [8];
    logic       seed_en;

    always #5 clk = ~clk;

    control_unit dut (
        .clk(clk), .rst(rst),
        .imem_req(imem_req), .imem_addr(imem_addr),
        .imem_ready(imem_ready), .imem_data(imem_data),
        .alu_op(alu_op), .source_sel(source_sel),
        .ins_immediate(ins_immediate), .pc(pc),
        .alu_result(alu_result),
        .sr1_addr(sr1_addr), .sr2_addr(sr2_addr), .dr_addr(dr_addr),
        .rf_we(rf_we), .cc(cc), .retire(retire), .halted(halted)
    );

    // Environment ALU responding to the DUT's controls
    always_comb begin
        logic [7:0] opb;
        logic [5:0] lea;
        opb = (source_sel == 2'b00) ? {3'b000, ins_immediate[4:0]} : regs[sr2_addr];
        lea = pc + ins_immediate;
        case (alu_op)
            2'b00:   alu_result = (source_sel == 2'b01) ? {2'b00, lea} : regs[sr1_addr] + opb;
            2'b01:   alu_result = regs[sr1_addr] & opb;
            2'b10:   alu_result = (source_sel == 2'b00) ? ~opb : ~regs[sr1_addr];
            default: alu_result = 8'h00;
        endcase
    end

    always @(posedge clk) begin
        if (seed_en) begin
            for (int i = 0; i < 8; i++) regs[i] <= mregs[i];
        end else if (rf_we) begin
            regs[dr_addr] <= alu_result;
        end
    end

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [2:0] nzp(input logic [7:0] v);
        if (v[7]) return 3'b100;
        if (v == 8'h00) return 3'b010;
        return 3'b001;
    endfunction

    // Called at a falling edge; asynchronous reset is checked mid-cycle
    task automatic do_reset();
        rst = 1'b1;
        #1;
        chk("rst_pc", {10'd0, pc}, 16'd0);
        chk("rst_cc", {13'd0, cc}, 16'd2);
        chk("rst_rf_we", {15'd0, rf_we}, 16'd0);
        chk("rst_retire", {15'd0, retire}, 16'd0);
        chk("rst_halted", {15'd0, halted}, 16'd0);
        @(negedge clk);
        rst = 1'b0;
        mpc = 6'd0;
        mcc = 3'b010;
    endtask

    // Executes one instruction starting at a falling edge in FETCH
    task automatic run(input logic [15:0] ins, input int dly);
        logic [3:0] op;
        logic [2:0] dr;
        logic [5:0] pcn;
        logic [7:0] b, res;
        logic       we, setcc, is_halt;
        logic [1:0] eop, esrc;
        op = ins[15:12];
        dr = ins[11:9];
        pcn = mpc + 6'd1;
        b = ins[5] ? {3'b000, ins[4:0]} : mregs[ins[2:0]];
        we = 1'b0; setcc = 1'b0; res = 8'h00; eop = 2'b00; esrc = 2'b00;
        is_halt = (op == 4'hF);
        case (op)
            4'h0: begin res = mregs[ins[8:6]] + b; we = 1; setcc = 1; eop = 2'b00; esrc = ins[5] ? 2'b00 : 2'b10; end
            4'h1: begin res = mregs[ins[8:6]] & b; we = 1; setcc = 1; eop = 2'b01; esrc = ins[5] ? 2'b00 : 2'b10; end
            4'h2: begin
                res = ins[5] ? ~{3'b000, ins[4:0]} : ~mregs[ins[8:6]];
                we = 1; setcc = 1; eop = 2'b10; esrc = ins[5] ? 2'b00 : 2'b10;
            end
            4'h3: begin res = {2'b00, pcn + ins[5:0]}; we = 1; eop = 2'b00; esrc = 2'b01; end
            default: ;
        endcase

        chk("fetch_req", {15'd0, imem_req}, 16'd1);
        chk("fetch_addr", {10'd0, imem_addr}, {10'd0, mpc});
        for (int k = 0; k < dly; k++) begin
            @(negedge clk);
            chk("wait_req", {15'd0, imem_req}, 16'd1);
            chk("wait_addr", {10'd0, imem_addr}, {10'd0, mpc});
        end
        imem_ready = 1'b1;
        imem_data  = ins;
        @(negedge clk);
        imem_ready = 1'b0;
        imem_data  = 16'($urandom);
        chk("dec_req", {15'd0, imem_req}, 16'd0);
        chk("dec_retire", {15'd0, retire}, 16'd0);
        chk("dec_rf_we", {15'd0, rf_we}, 16'd0);
        chk("dec_pc", {10'd0, pc}, {10'd0, pcn});
        @(negedge clk);
        chk("ex_retire", {15'd0, retire}, 16'd1);
        chk("ex_req", {15'd0, imem_req}, 16'd0);
        chk("ex_rf_we", {15'd0, rf_we}, {15'd0, we});
        chk("ex_pc", {10'd0, pc}, {10'd0, pcn});
        if (we) begin
            chk("ex_alu_op", {14'd0, alu_op}, {14'd0, eop});
            chk("ex_src", {14'd0, source_sel}, {14'd0, esrc});
            chk("ex_dr", {13'd0, dr_addr}, {13'd0, dr});
            chk("ex_result", {8'd0, alu_result}, {8'd0, res});
        end

        mpc = pcn;
        if (op == 4'h4 && (ins[11:9] & mcc) != 3'b000) mpc = pcn + ins[5:0];
        if (setcc) mcc = nzp(res);
        if (we) mregs[dr] = res;
        @(negedge clk);
        chk("post_cc", {13'd0, cc}, {13'd0, mcc});
        chk("post_halted", {15'd0, halted}, {15'd0, is_halt});
        chk("post_req", {15'd0, imem_req}, {15'd0, !is_halt});
        chk("post_addr", {10'd0, imem_addr}, {10'd0, mpc});
        chk("post_retire", {15'd0, retire}, 16'd0);
        if (we) chk("post_reg", {8'd0, regs[dr]}, {8'd0, res});
    endtask

    // Unconditional branch so the next fetch comes from address t
    task automatic goto_pc(input logic [5:0] t);
        logic [5:0] off;
        off = t - mpc - 6'd1;
        run({4'h4, 3'b111, 3'b000, off}, 0);
    endtask

    initial begin
        logic [3:0] rop;
        rst = 1'b1;
        imem_ready = 1'b0;
        imem_data = 16'h0000;
        seed_en = 1'b1;
        mregs[0] = 8'h00;
        for (int i = 1; i < 8; i++) mregs[i] = 8'($urandom);
        mpc = 6'd0;
        mcc = 3'b010;
        @(negedge clk);
        seed_en = 1'b0;
        do_reset();

        run(16'h0225, 0);                // ADDI R1,R0,#5 -> cc=001
        run(16'h0A41, 4);                // ADD R5,R1,R1 with a slow fetch
        run(16'h2440, 0);                // NOT R2,R1 -> 0xFA, cc=100
        run(16'h16A5, 0);                // AND R3,R2,#5 -> 0, cc=010
        run(16'h1820, 0);                // AND R4,R0,#0 -> cc=010
        goto_pc(6'd10);
        run(16'h4403, 0);                // BRz +3 taken -> 14
        run(16'h0921, 0);                // ADD R4,R4,#1 -> cc=001
        goto_pc(6'd10);
        run(16'h4403, 0);                // BRz +3 not taken -> 11
        goto_pc(6'd62);
        run(16'h4E05, 0);                // wraps to 4
        goto_pc(6'd63);
        run(16'h3606, 1);                // LEA R3,#6 at 63, pc output 0
        run(16'h4005, 0);                // BR nzp=000 behaves as a NOP
        run(16'h7123, 2);                // unassigned opcode

        for (int n = 0; n < 150; n++) begin
            rop = 4'($urandom_range(0, 7));
            if (rop > 4'd4) rop = 4'($urandom_range(5, 14));
            run({rop, 12'($urandom)}, $urandom_range(0, 2));
        end

        // Reset during EXECUTE of a writing instruction must cancel it
        imem_ready = 1'b1;
        imem_data  = 16'h0A3F;           // ADDI R5,R0,#31
        @(negedge clk);
        imem_ready = 1'b0;
        @(negedge clk);
        chk("abort_ex_we", {15'd0, rf_we}, 16'd1);
        do_reset();
        chk("abort_reg", {8'd0, regs[5]}, {8'd0, mregs[5]});
        chk("abort_addr", {10'd0, imem_addr}, 16'd0);

        // Reset while a fetch is pending
        @(negedge clk);
        do_reset();
        run(16'h0C7F, 0);                // ADDI R6,R1,#31

        // HALT holds everything until reset
        run(16'hF000, 1);
        for (int k = 0; k < 12; k++) begin
            @(negedge clk);
            chk("halt_req", {15'd0, imem_req}, 16'd0);
            chk("halt_flag", {15'd0, halted}, 16'd1);
            chk("halt_rf_we", {15'd0, rf_we}, 16'd0);
            chk("halt_pc", {10'd0, pc}, {10'd0, mpc});
            chk("halt_cc", {13'd0, cc}, {13'd0, mcc});
        end
        do_reset();
        run(16'h0E21, 0);                // ADDI R7,R0,#1 after restart

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation exceeded time budget");
        $fatal(1, "timeout");
    end

endmodule
